crc_serial_engine: RTL

- Parametrised bit-serial CRC engine for the USB packet path.
- Generalises the fixed CRC5 generator to any width and polynomial, so one block serves CRC5 (token) and CRC16 (data) instances.
- Adds a per-bit valid, so the bit-stuffer can stall both input sampling and CRC emission.
- Adds a check mode that compares the final remainder against the polynomial residue and flags errors on the receive path.

---
 rtl/crc_serial_engine.sv | 119 +++++++++++
 1 files changed

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC engine: absorbs a valid-qualified MSB-first bit stream, then either
// emits the inverted remainder (generate) or compares it against the residue (check).
module crc_serial_engine #(
  parameter int               WIDTH   = 5,
  parameter logic [WIDTH-1:0] POLY    = 5'h05,
  parameter logic [WIDTH-1:0] INIT    = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESIDUE = 5'h0C
) (
  input  logic clk,
  input  logic rst,
  input  logic crc_start,
  input  logic chk_mode,
  input  logic s_in,
  input  logic s_valid,
  input  logic out_en,
  output logic crc_out,
  output logic crc_ready,
  output logic crc_done,
  output logic crc_ok,
  input  logic crc_rec
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, EMIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             chk_q, chk_d;
  logic             ok_q, ok_d;

  logic             fb;
  logic [WIDTH-1:0] rem_upd;
  logic             rem_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= INIT;
      cnt_q   <= '0;
      chk_q   <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      ok_q    <= ok_d;
    end
  end

  always_comb begin
    fb      = s_in ^ rem_q[WIDTH-1];
    rem_upd = {rem_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    ok_d    = ok_q;

    unique case (state_q)
      IDLE: begin
        // rem_q is INIT here, so the first bit can be absorbed on the start cycle
        if (crc_start) begin
          state_d = CALC;
          chk_d   = chk_mode;
          if (s_valid) rem_d = rem_upd;
        end
      end
      CALC: begin
        if (!crc_start) begin
          if (chk_q) begin
            state_d = DONE;
            ok_d    = (rem_q == RESIDUE);
          end else begin
            state_d = EMIT;
            cnt_d   = '0;
          end
        end else if (s_valid) begin
          rem_d = rem_upd;
        end
      end
      EMIT: begin
        if (out_en) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
            ok_d    = 1'b0;
          end
        end
      end
      DONE: begin
        if (crc_rec) begin
          state_d = IDLE;
          rem_d   = INIT;
          ok_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select rem[WIDTH-1-cnt] without an oversized index
  always_comb begin
    rem_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_q == CW'(WIDTH - 1 - i)) rem_bit = rem_q[i];
    end
  end

  assign crc_ready = (state_q == EMIT);
  assign crc_out   = crc_ready & ~rem_bit;
  assign crc_done  = (state_q == DONE);
  assign crc_ok    = crc_done & ok_q;

endmodule
